// File: rtl/io_port_seq_if.sv
// Bus bundle between the Z80 side and the I/O-cycle sequencer.
// master: drives the Z80 address and strobes (CPU model / bench).
// slave : the sequencer, which drives the latch controls and status.
interface io_port_seq_if #(
  parameter int NUM_PORTS = 4
);
  logic [7:0]           addr;
  logic                 IORQ_L;
  logic                 RD_L;
  logic                 WR_L;
  logic                 M1_L;
  logic [NUM_PORTS-1:0] le_h;
  logic [NUM_PORTS-1:0] oe_l;
  logic                 dbus_dir_h;
  logic                 wait_l;
  logic                 busy_h;
  logic                 err_h;

  modport master (
    output addr, IORQ_L, RD_L, WR_L, M1_L,
    input  le_h, oe_l, dbus_dir_h, wait_l, busy_h, err_h
  );

  modport slave (
    input  addr, IORQ_L, RD_L, WR_L, M1_L,
    output le_h, oe_l, dbus_dir_h, wait_l, busy_h, err_h
  );
endinterface

// File: rtl/io_port_seq.sv
// Z80 I/O-cycle sequencer for the io board CPLD.
// Decodes IN/OUT cycles against NUM_PORTS consecutive port addresses starting
// at BASE_ADDR and drives the latch-enable / output-enable pins of the port
// latches plus the data-bus direction.
// Optional feature macro: IO_PORT_SEQ_WAIT_EN -- when defined, a legal in-range
// cycle is stretched by holding wait_l low for WAIT_CYCLES clocks before the
// strobe phase. When undefined, wait_l is tied high.
module io_port_seq #(
  parameter int         NUM_PORTS   = 4,
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         LE_PULSE    = 2,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_h,
  io_port_seq_if.slave  bus
);

  // One shared counter times both the WAIT phase and the latch-enable pulse.
  localparam int CNT_MAX = (LE_PULSE > WAIT_CYCLES) ? LE_PULSE : WAIT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WAIT      = 3'd2,
    ST_WR_STROBE = 3'd3,
    ST_RD_ACTIVE = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_sync_meta;
  logic [3:0]           r_sync;
  logic                 w_iorq_l;
  logic                 w_rd_l;
  logic                 w_wr_l;
  logic                 w_m1_l;
  logic [8:0]           w_off;
  logic                 w_in_range;
  logic [2:0]           w_idx_now;
  logic [2:0]           w_idx_sel;
  logic [2:0]           r_idx;
  logic                 w_capture;
  logic                 w_err_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_PORTS-1:0] w_onehot;
  logic [NUM_PORTS-1:0] r_le_h;
  logic [NUM_PORTS-1:0] r_oe_l;
  logic                 r_dbus_dir_h;
  logic                 r_busy_h;
  logic                 r_err_h;
`ifdef IO_PORT_SEQ_WAIT_EN
  logic                 r_is_rd;
  logic                 r_wait_l;
`endif

  // Two-flop synchronizers for the asynchronous Z80 strobes (idle = high).
  always_ff @(posedge clk) begin
    if (reset_h) begin
      r_sync_meta <= 4'b1111;
      r_sync      <= 4'b1111;
    end else begin
      r_sync_meta <= {bus.M1_L, bus.WR_L, bus.RD_L, bus.IORQ_L};
      r_sync      <= r_sync_meta;
    end
  end

  assign w_iorq_l = r_sync[0];
  assign w_rd_l   = r_sync[1];
  assign w_wr_l   = r_sync[2];
  assign w_m1_l   = r_sync[3];

  // 9-bit offset: bit 8 set means addr is below BASE_ADDR; no address wrap.
  assign w_off      = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign w_in_range = ~w_off[8] && (w_off[7:0] < 8'(NUM_PORTS));
  assign w_idx_now  = w_off[2:0];

  // During DECODE the port index comes straight from the bus, later from the
  // captured copy, so the registered outputs see the right port on entry.
  assign w_idx_sel = (r_state == ST_DECODE) ? w_idx_now : r_idx;

  // Port index to one-hot select.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_onehot[i] = (w_idx_sel == 3'(i));
    end
  end

  // Next-state logic and error / capture decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_iorq_l && w_m1_l) begin
          w_state_nxt = ST_DECODE;
        end else if (!w_iorq_l) begin
          // Interrupt acknowledge: not ours, just wait for it to end.
          w_state_nxt = ST_FINISH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (!w_in_range) begin
          // Another board owns this port; stay quiet.
          w_state_nxt = ST_FINISH;
        end else if (w_iorq_l) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_rd_l && !w_wr_l) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_FINISH;
        end else if (w_rd_l && w_wr_l) begin
          w_state_nxt = ST_DECODE;
        end else begin
          w_capture = 1'b1;
`ifdef IO_PORT_SEQ_WAIT_EN
          w_state_nxt = ST_WAIT;
`else
          w_state_nxt = (!w_wr_l) ? ST_WR_STROBE : ST_RD_ACTIVE;
`endif
        end
      end
`ifdef IO_PORT_SEQ_WAIT_EN
      ST_WAIT: begin
        if (w_iorq_l) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
          w_state_nxt = r_is_rd ? ST_RD_ACTIVE : ST_WR_STROBE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
`endif
      ST_WR_STROBE: begin
        if (w_iorq_l || w_wr_l) begin
          // Cycle ended early: the latched data is not trustworthy.
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(LE_PULSE - 1)) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_state_nxt = ST_WR_STROBE;
        end
      end
      ST_RD_ACTIVE: begin
        if (w_iorq_l || w_rd_l) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RD_ACTIVE;
        end
      end
      ST_FINISH: begin
        if (w_iorq_l) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FINISH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_h) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase counter: restarts on every state change, counts while staying.
  always_ff @(posedge clk) begin
    if (reset_h) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Capture the port index (and direction) when a legal cycle is accepted.
  always_ff @(posedge clk) begin
    if (reset_h) begin
      r_idx <= 3'd0;
`ifdef IO_PORT_SEQ_WAIT_EN
      r_is_rd <= 1'b0;
`endif
    end else if (w_capture) begin
      r_idx <= w_idx_now;
`ifdef IO_PORT_SEQ_WAIT_EN
      r_is_rd <= ~w_rd_l;
`endif
    end
  end

  // Registered outputs derived from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset_h) begin
      r_le_h       <= '0;
      r_oe_l       <= '1;
      r_dbus_dir_h <= 1'b0;
      r_busy_h     <= 1'b0;
      r_err_h      <= 1'b0;
    end else begin
      r_le_h       <= (w_state_nxt == ST_WR_STROBE) ? w_onehot : '0;
      r_oe_l       <= (w_state_nxt == ST_RD_ACTIVE) ? ~w_onehot : '1;
      r_dbus_dir_h <= (w_state_nxt == ST_RD_ACTIVE);
      r_busy_h     <= (w_state_nxt != ST_IDLE);
      r_err_h      <= w_err_nxt;
    end
  end

`ifdef IO_PORT_SEQ_WAIT_EN
  // WAIT request held low for the whole WAIT phase.
  always_ff @(posedge clk) begin
    if (reset_h) begin
      r_wait_l <= 1'b1;
    end else begin
      r_wait_l <= (w_state_nxt != ST_WAIT);
    end
  end

  assign bus.wait_l = r_wait_l;
`else
  assign bus.wait_l = 1'b1;
`endif

  assign bus.le_h       = r_le_h;
  assign bus.oe_l       = r_oe_l;
  assign bus.dbus_dir_h = r_dbus_dir_h;
  assign bus.busy_h     = r_busy_h;
  assign bus.err_h      = r_err_h;

endmodule
